ex_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the EX stage: executes the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over multiple cycles. It holds the front of the pipeline with a stall request until the result is ready. Sits beside the single-cycle ALU in EX; the EX result mux selects `result` when `valid_out` is high. Its EX/MEM write-back tag is `rd_out`.

---
 rtl/ex_muldiv_seq.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes; the sign is fixed up once at the end.
module ex_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            valid_out,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES   = '1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]     count_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   addend_reg;
    logic [2:0]        op_reg;
    logic [4:0]        rd_reg;
    logic              sign_reg;

    // Operand decode, only meaningful in the accepting cycle
    logic            a_signed, b_signed, s_a, s_b, is_div;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special, sign_in, accept;
    logic [XLEN-1:0] special_result;

    assign is_div   = op[2];
    assign a_signed = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
    assign b_signed = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
    assign s_a      = a_signed & rs1_data[XLEN-1];
    assign s_b      = b_signed & rs2_data[XLEN-1];
    assign a_mag    = s_a ? (~rs1_data + 1'b1) : rs1_data;
    assign b_mag    = s_b ? (~rs2_data + 1'b1) : rs2_data;
    // Remainder takes the dividend's sign; products and quotients take the xor
    assign sign_in  = (op[2] & op[1]) ? s_a : (s_a ^ s_b);

    assign div_zero = is_div & (rs2_data == '0);
    assign div_ovf  = ((op == OP_DIV) | (op == OP_REM)) &
                      (rs1_data == MIN_NEG) & (rs2_data == ALL_ONES);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = op[1] ? rs1_data : ALL_ONES;
        else if (div_ovf)
            special_result = op[1] ? '0 : MIN_NEG;
    end

    assign accept = (state_reg == IDLE) & start & ~flush;

    // One iteration of either algorithm on the shared accumulator
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, acc_step;

    assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                       (acc_reg[0] ? {1'b0, addend_reg} : '0);
    assign mul_next  = {mul_sum, acc_reg[XLEN-1:1]};
    assign div_trial = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]} - {1'b0, addend_reg};
    assign div_next  = div_trial[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    assign acc_step  = op_reg[2] ? div_next : mul_next;

    // Final sign fix-up and half/quotient/remainder select
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   div_raw, div_signed, fix_result;

    assign prod_signed = sign_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign div_raw     = op_reg[1] ? acc_reg[2*XLEN-1:XLEN] : acc_reg[XLEN-1:0];
    assign div_signed  = sign_reg ? (~div_raw + 1'b1) : div_raw;

    always_comb begin
        fix_result = div_signed;
        if (!op_reg[2])
            fix_result = (op_reg == OP_MUL) ? prod_signed[XLEN-1:0]
                                            : prod_signed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (flush)
                    state_next = IDLE;
                else if (count_reg == '0)
                    state_next = FIX;
            end
            FIX:  state_next = flush ? IDLE : DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        stall_req = accept | (state_reg == CALC) | (state_reg == FIX);
        valid_out = (state_reg == DONE) & ~flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            acc_reg    <= '0;
            addend_reg <= '0;
            op_reg     <= '0;
            rd_reg     <= '0;
            sign_reg   <= 1'b0;
            result     <= '0;
            rd_out     <= '0;
        end else if (accept) begin
            op_reg     <= op;
            rd_reg     <= rd_in;
            sign_reg   <= sign_in;
            count_reg  <= LAST_COUNT;
            addend_reg <= is_div ? b_mag : a_mag;
            acc_reg    <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            if (special) begin
                result <= special_result;
                rd_out <= rd_in;
            end
        end else if (state_reg == CALC && !flush) begin
            count_reg <= count_reg - 1'b1;
            acc_reg   <= acc_step;
        end else if (state_reg == FIX && !flush) begin
            result <= fix_result;
            rd_out <= rd_reg;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: vector table through a scoreboard queue,
// plus hand-written flush, reset and start-while-busy sequences.
module tb_ex_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        valid_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    ex_muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .valid_out (valid_out),
        .result    (result),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          t0;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[20];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Waits for valid_out, pops the scoreboard and checks the result, tag, latency and stall profile
    task automatic wait_result(input string name);
        bit   got      = 0;
        bit   stall_ok = 1;
        exp_t e;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (valid_out) begin
                got = 1;
                break;
            end
            if (!stall_req || !busy) stall_ok = 0;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_valid_out required=valid_out_within_60_cycles", name);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_valid actual=valid_out required=no_pending_op", name);
        end else begin
            e = sb.pop_front();
            check({name, "_result"}, result, e.res);
            check({name, "_rd_out"}, 32'(rd_out), 32'(e.rd));
            check({name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            check({name, "_stall_in_done"}, 32'(stall_req), 32'd0);
            check({name, "_stall_busy_profile"}, 32'(stall_ok), 32'd1);
            $display("txn %s res=0x%08h rd=%0d lat=%0d", name, result, rd_out, cyc - e.t0);
        end
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        check({name, "_valid_pulse"}, 32'(valid_out), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat, input int hold);
        exp_t e;
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = o;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        e.res = exp;
        e.rd  = rd;
        e.lat = lat;
        e.t0  = cyc;
        sb.push_back(e);
        @(negedge clk);
        check({name, "_stall_accept"}, 32'(stall_req), 32'd1);
        // Keep start asserted with fresh operands; the unit must ignore them
        repeat (hold) begin
            @(posedge clk);
            #1;
            op       = 3'($urandom);
            rs1_data = $urandom;
            rs2_data = $urandom;
            rd_in    = 5'($urandom);
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_in    = 5'($urandom);
        wait_result(name);
    endtask

    initial begin
        int t0;

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0};
        vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 0};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 0};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0};
        vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34, 0};
        vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34, 0};
        vecs[8]  = '{3'b101, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1,  0};
        vecs[9]  = '{3'b110, 32'h12345678, 32'd0,        32'h12345678, 1,  0};
        vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0};
        vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0};
        vecs[12] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34, 0};
        vecs[13] = '{3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        34, 0};
        vecs[14] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 0};
        vecs[15] = '{3'b100, 32'h80000000, 32'd2,        32'hC0000000, 34, 0};
        vecs[16] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 0};
        vecs[17] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, 0};
        vecs[18] = '{3'b100, 32'd0,        32'd0,        32'hFFFFFFFF, 1,  0};
        vecs[19] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 5};

        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 3'b000;
        rs1_data = '0;
        rs2_data = '0;
        rd_in    = '0;
        flush    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_stall", 32'(stall_req), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd_out", 32'(rd_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   5'(i + 1), vecs[i].exp, vecs[i].lat, vecs[i].hold);

        // Flush a DIV in T+10, then a MUL in T+12 must complete normally
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = 3'b100;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        rd_in    = 5'd9;
        t0       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_cycle_offset", 32'(cyc - t0), 32'd10);
        flush = 1'b1;
        @(negedge clk);
        check("flush_valid_forced_low", 32'(valid_out), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_t11", 32'(busy), 32'd0);
        check("flush_stall_t11", 32'(stall_req), 32'd0);
        run_op("after_flush_mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd17, 32'hFFFFFFEB, 34, 0);

        // Asynchronous reset in the middle of a MUL, restart in T+8
        @(posedge clk);
        #1;
        start    = 1'b1;
        op       = 3'b000;
        rs1_data = 32'd7;
        rs2_data = 32'hFFFFFFFD;
        rd_in    = 5'd5;
        t0       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(valid_out), 32'd0);
        check("midreset_stall", 32'(stall_req), 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_rd_out", 32'(rd_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postreset_valid_t6", 32'(valid_out), 32'd0);
        @(negedge clk);
        check("postreset_valid_t7", 32'(valid_out), 32'd0);
        check("postreset_busy_t7", 32'(busy), 32'd0);
        run_op("restart_mul", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 34, 0);
        check("restart_offset", 32'(cyc - t0), 32'd43);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
